// File: rtl/pattern_gen_pkg.sv
// Shared types and helpers for the multi-mode test pattern generator.
package pattern_gen_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [2:0] {
    MODE_ZERO  = 3'd0,
    MODE_COUNT = 3'd1,
    MODE_GRAY  = 3'd2,
    MODE_WALK  = 3'd3,
    MODE_ALT   = 3'd4,
    MODE_LFSR  = 3'd5
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Reserved encodings fall back to the static-zero pattern.
  function automatic mode_e decode_mode(input logic [2:0] m);
    case (m)
      3'd1:    return MODE_COUNT;
      3'd2:    return MODE_GRAY;
      3'd3:    return MODE_WALK;
      3'd4:    return MODE_ALT;
      3'd5:    return MODE_LFSR;
      default: return MODE_ZERO;
    endcase
  endfunction

  // Value the pattern takes right after a load; also the wrap reference.
  function automatic logic [MAX_W-1:0] init_value(input mode_e mode,
                                                  input int unsigned width,
                                                  input logic [MAX_W-1:0] seed);
    logic [MAX_W-1:0] v;
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] s;
    v    = '0;
    mask = (width >= MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
    s    = seed & mask;
    case (mode)
      MODE_WALK: v = 64'd1;
      MODE_ALT: begin
        for (int unsigned i = 0; i < MAX_W; i++) begin
          if ((i % 2 == 0) && (i < (width / 2) * 2)) v = v | (64'd1 << i);
        end
      end
      MODE_LFSR: v = (s == '0) ? 64'd1 : s;
      default:   v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/pattern_prescaler.sv
// Rate prescaler: emits a tick every div_q+1 running cycles.
module pattern_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             run_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;

  // A load suppresses the tick so the restart is never overtaken by an advance.
  assign tick_o = run_i && !load_i && (cnt_q == div_q);

  // Divisor latch and cycle counter; frozen whenever not running.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      div_q <= div_i;
      cnt_q <= '0;
    end else if (run_i) begin
      if (cnt_q == div_q) cnt_q <= '0;
      else                cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// Multi-mode test pattern generator for the logic analyser probe channels.
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIV_W = 16,
  parameter logic [63:0] POLY  = 64'h80200003,
  parameter logic [63:0] SEED  = 64'd1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_load_i,
  input  logic [2:0]       mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] pattern_o,
  output logic             step_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] POLY_W = POLY[WIDTH-1:0];

  state_e           state_q, state_d;
  mode_e            mode_q;
  logic [WIDTH-1:0] pat_q, bin_q;
  logic [WIDTH-1:0] pat_nxt, bin_nxt;
  logic [WIDTH-1:0] init_cur, init_load;
  logic             step_q, wrap_q;
  logic             run, tick;

  assign run = (state_q == RUN) && en_i;

  pattern_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (cfg_load_i),
    .div_i  (div_i),
    .run_i  (run),
    .tick_o (tick)
  );

  // Run-enable state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state follows en_i.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i)  state_d = RUN;
      RUN:     if (!en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next pattern for the latched mode and the two INIT references.
  // Gray keeps its own binary counter so the output stays registered.
  always_comb begin
    init_cur  = WIDTH'(init_value(mode_q, WIDTH, SEED));
    init_load = WIDTH'(init_value(decode_mode(mode_i), WIDTH, SEED));
    bin_nxt   = bin_q + 1'b1;
    pat_nxt   = '0;
    case (mode_q)
      MODE_COUNT: pat_nxt = bin_nxt;
      MODE_GRAY:  pat_nxt = bin_nxt ^ (bin_nxt >> 1);
      MODE_WALK:  pat_nxt = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
      MODE_ALT:   pat_nxt = ~pat_q;
      MODE_LFSR:  pat_nxt = (pat_q >> 1) ^ (pat_q[0] ? POLY_W : '0);
      default:    pat_nxt = '0;
    endcase
  end

  // Pattern, mode latch and the step/wrap pulses; load beats advance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= MODE_ZERO;
      pat_q  <= '0;
      bin_q  <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (cfg_load_i) begin
      mode_q <= decode_mode(mode_i);
      pat_q  <= init_load;
      bin_q  <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (tick) begin
      pat_q  <= pat_nxt;
      bin_q  <= bin_nxt;
      step_q <= 1'b1;
      wrap_q <= (pat_nxt == init_cur);
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end
  end

  assign pattern_o = pat_q;
  assign step_o    = step_q;
  assign wrap_o    = wrap_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen (WIDTH=8, POLY=B8, SEED=0).
module tb_pattern_gen;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       cfg_load_i;
  logic [2:0] mode_i;
  logic [7:0] div_i;
  logic       en_i;
  logic [7:0] pattern_o;
  logic       step_o;
  logic       wrap_o;

  pattern_gen #(
    .WIDTH (8),
    .DIV_W (8),
    .POLY  (64'hB8),
    .SEED  (64'd0)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cfg_load_i (cfg_load_i),
    .mode_i     (mode_i),
    .div_i      (div_i),
    .en_i       (en_i),
    .pattern_o  (pattern_o),
    .step_o     (step_o),
    .wrap_o     (wrap_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] pat;
    logic       step;
    logic       wrap;
  } exp_t;

  typedef struct {
    bit         ld;
    int         md;
    int         dv;
    bit         en;
    int         n;
    logic [7:0] exp_pat;
    int         exp_steps;
  } vec_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int         m_mode;
  logic [7:0] m_div, m_cnt, m_bin, m_pat;
  bit         m_run;

  // Observations of the last sampled cycle
  logic [7:0] last_pat;
  logic       last_step, last_wrap;
  int         stp_cnt, wrp_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_init(input int md);
    case (md)
      3:       return 8'h01;
      4:       return 8'h55;
      5:       return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_div = 0; m_cnt = 0; m_bin = 0; m_pat = 0; m_run = 0;
  endtask

  task automatic model_edge(input bit ld, input int md, input logic [7:0] dv, input bit en);
    exp_t e;
    bit   active;
    active = m_run && en;
    e.step = 1'b0;
    e.wrap = 1'b0;
    if (ld) begin
      m_mode = (md > 5) ? 0 : md;
      m_div  = dv;
      m_cnt  = 0;
      m_bin  = 0;
      m_pat  = m_init(m_mode);
    end else if (active) begin
      if (m_cnt == m_div) begin
        m_cnt = 0;
        case (m_mode)
          1: begin m_bin = m_bin + 8'd1; m_pat = m_bin; end
          2: begin m_bin = m_bin + 8'd1; m_pat = m_bin ^ (m_bin >> 1); end
          3: m_pat = {m_pat[6:0], m_pat[7]};
          4: m_pat = ~m_pat;
          5: m_pat = (m_pat >> 1) ^ (m_pat[0] ? 8'hB8 : 8'h00);
          default: m_pat = 8'h00;
        endcase
        e.step = 1'b1;
        e.wrap = (m_pat == m_init(m_mode));
      end else begin
        m_cnt = m_cnt + 8'd1;
      end
    end
    m_run = en;
    e.pat = m_pat;
    exp_q.push_back(e);
  endtask

  // One clock: drive at negedge, predict, sample 1 time unit after posedge.
  task automatic cyc(input bit ld, input int md, input int dv, input bit en);
    exp_t e;
    logic [7:0] dv8;
    logic [2:0] md3;
    dv8 = dv[7:0];
    md3 = md[2:0];
    @(negedge clk_i);
    cfg_load_i = ld;
    mode_i     = md3;
    div_i      = dv8;
    en_i       = en;
    model_edge(ld, md, dv8, en);
    @(posedge clk_i);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: queue empty, got pattern %0h", pattern_o);
    end else begin
      e = exp_q.pop_front();
      check("pattern_o", {56'd0, pattern_o}, {56'd0, e.pat});
      check("step_o", {63'd0, step_o}, {63'd0, e.step});
      check("wrap_o", {63'd0, wrap_o}, {63'd0, e.wrap});
    end
    last_pat  = pattern_o;
    last_step = step_o;
    last_wrap = wrap_o;
    if (step_o) stp_cnt++;
    if (wrap_o) wrp_cnt++;
    cfg_load_i = 1'b0;
  endtask

  vec_t       tbl[10];
  logic [7:0] walk_exp[8];
  logic [7:0] gray_exp[7];
  logic [7:0] alt_exp[4];
  bit         seen[256];
  int         distinct;
  int         wrap_step;

  initial begin
    tbl[0] = '{1, 1, 3, 1, 1, 8'h00, 0};
    tbl[1] = '{0, 1, 0, 1, 8, 8'h02, 2};
    tbl[2] = '{0, 1, 0, 0, 5, 8'h02, 0};
    tbl[3] = '{0, 1, 0, 1, 4, 8'h02, 0};
    tbl[4] = '{0, 1, 0, 1, 1, 8'h03, 1};
    tbl[5] = '{1, 6, 0, 1, 1, 8'h00, 0};
    tbl[6] = '{0, 6, 0, 1, 3, 8'h00, 3};
    tbl[7] = '{1, 1, 1, 0, 1, 8'h00, 0};
    tbl[8] = '{0, 1, 1, 1, 1, 8'h00, 0};
    tbl[9] = '{0, 1, 1, 1, 4, 8'h02, 2};
    walk_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    gray_exp = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04};
    alt_exp  = '{8'hAA, 8'h55, 8'hAA, 8'h55};

    rst_ni = 1'b0; cfg_load_i = 1'b0; mode_i = '0; div_i = '0; en_i = 1'b0;
    model_reset();
    #23;
    check("reset_pattern", {56'd0, pattern_o}, 64'd0);
    check("reset_step", {63'd0, step_o}, 64'd0);
    check("reset_wrap", {63'd0, wrap_o}, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Binary count, every cycle, full wrap
    cyc(1, 1, 0, 1);
    check("count_init", {56'd0, last_pat}, 64'd0);
    stp_cnt = 0; wrp_cnt = 0;
    for (int i = 0; i < 256; i++) cyc(0, 1, 0, 1);
    check("count_steps", stp_cnt, 256);
    check("count_wraps", wrp_cnt, 1);
    check("count_wrap_last", {63'd0, last_wrap}, 64'd1);
    check("count_end", {56'd0, last_pat}, 64'd0);

    // Prescaler, hold, reserved mode, ignored div change
    for (int r = 0; r < 10; r++) begin
      stp_cnt = 0;
      for (int k = 0; k < tbl[r].n; k++) cyc(tbl[r].ld, tbl[r].md, tbl[r].dv, tbl[r].en);
      check($sformatf("tbl%0d_pattern", r), {56'd0, last_pat}, {56'd0, tbl[r].exp_pat});
      check($sformatf("tbl%0d_steps", r), stp_cnt, tbl[r].exp_steps);
    end

    // Walking one
    cyc(1, 3, 0, 1);
    check("walk_init", {56'd0, last_pat}, 64'h01);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 3, 0, 1);
      check($sformatf("walk%0d", i), {56'd0, last_pat}, {56'd0, walk_exp[i]});
      check($sformatf("walk_wrap%0d", i), {63'd0, last_wrap}, (i == 7) ? 64'd1 : 64'd0);
    end

    // Gray count
    cyc(1, 2, 0, 1);
    check("gray_init", {56'd0, last_pat}, 64'h00);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 2, 0, 1);
      check($sformatf("gray%0d", i), {56'd0, last_pat}, {56'd0, gray_exp[i]});
    end

    // Load alternating mode mid-count, on a tick cycle
    cyc(1, 1, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1);
    check("alt_pre", {56'd0, last_pat}, 64'h05);
    cyc(1, 4, 0, 1);
    check("alt_load_pattern", {56'd0, last_pat}, 64'h55);
    check("alt_load_step", {63'd0, last_step}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 4, 0, 1);
      check($sformatf("alt%0d", i), {56'd0, last_pat}, {56'd0, alt_exp[i]});
      check($sformatf("alt_wrap%0d", i), {63'd0, last_wrap}, (i % 2 == 1) ? 64'd1 : 64'd0);
    end

    // LFSR full period, seed 0 replaced by 1
    cyc(1, 5, 0, 1);
    check("lfsr_init", {56'd0, last_pat}, 64'h01);
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    distinct = 0; wrap_step = -1; wrp_cnt = 0;
    for (int i = 0; i < 255; i++) begin
      cyc(0, 5, 0, 1);
      if (!seen[last_pat]) distinct++;
      seen[last_pat] = 1'b1;
      if (last_wrap && wrap_step < 0) wrap_step = i + 1;
    end
    check("lfsr_distinct", distinct, 255);
    check("lfsr_no_zero", {63'd0, seen[0]}, 64'd0);
    check("lfsr_wraps", wrp_cnt, 1);
    check("lfsr_wrap_step", wrap_step, 255);
    cyc(0, 5, 0, 1);
    cyc(0, 5, 0, 1);

    // Asynchronous reset mid-run
    #2;
    check("pre_reset_step", {63'd0, step_o}, 64'd1);
    en_i   = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("async_pattern", {56'd0, pattern_o}, 64'd0);
    check("async_step", {63'd0, step_o}, 64'd0);
    check("async_wrap", {63'd0, wrap_o}, 64'd0);
    model_reset();
    rst_ni = 1'b1;

    // After reset, mode 0 until a load even though mode_i says LFSR
    stp_cnt = 0;
    for (int i = 0; i < 4; i++) cyc(0, 5, 0, 1);
    check("post_reset_pattern", {56'd0, last_pat}, 64'd0);
    check("post_reset_steps", stp_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule
